// File: rtl/regfile_mp.sv
// Purpose: parametrised 1W/2R register file with a post-reset clear sequencer, wr_err flag and optional REGFILE_BYPASS_EN forwarding.
// Latency: reads are combinational; writes become visible on the next cycle, or the same cycle when REGFILE_BYPASS_EN is defined.
// Backpressure: none; writes during clear or to a hardwired-zero register 0 are dropped and flagged on wr_err.
module regfile_mp #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       ADDR_W   = 5,
    parameter int unsigned       ZERO_REG = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              busy,
    output logic              wr_err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic              wr_err_q, wr_err_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic              in_clear;
    logic              zero_wr;
    logic              wr_accept;
    logic [DATA_W-1:0] clr_val;

    assign in_clear  = (state_q == ST_CLEAR);
    assign zero_wr   = (ZERO_REG != 0) && (waddr == '0);
    assign wr_accept = we && !in_clear && !rst && !zero_wr;
    assign clr_val   = ((ZERO_REG != 0) && (clr_idx_q == '0)) ? '0 : INIT_VAL;

    assign busy   = in_clear;
    assign wr_err = wr_err_q;

    // Clear walks every index once; the edge that writes the last index also leaves CLEAR.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            ST_CLEAR: begin
                clr_idx_d = clr_idx_q + ADDR_W'(1);
                if (&clr_idx_q) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_idx_d = '0;
            end
        endcase
    end

    always_comb begin
        wr_err_d = we && !wr_accept;
    end

    always_comb begin
        mem_d = mem_q;
        if (!rst) begin
            if (in_clear) begin
                mem_d[clr_idx_q] = clr_val;
            end else if (wr_accept) begin
                mem_d[waddr] = wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
            wr_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            wr_err_q  <= wr_err_d;
        end
        mem_q <= mem_d;
    end

    // Busy and zero-register forcing override forwarding.
    always_comb begin
        rdata1 = mem_q[raddr1];
`ifdef REGFILE_BYPASS_EN
        if (wr_accept && (raddr1 == waddr)) begin
            rdata1 = wdata;
        end
`endif
        if (in_clear || ((ZERO_REG != 0) && (raddr1 == '0))) begin
            rdata1 = '0;
        end
    end

    always_comb begin
        rdata2 = mem_q[raddr2];
`ifdef REGFILE_BYPASS_EN
        if (wr_accept && (raddr2 == waddr)) begin
            rdata2 = wdata;
        end
`endif
        if (in_clear || ((ZERO_REG != 0) && (raddr2 == '0))) begin
            rdata2 = '0;
        end
    end

endmodule
